// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory loader.
//   IMEM_SIZE_DEFAULT : default instruction memory size in bytes
//   BYTES_PER_WORD    : bytes per instruction word (big-endian serialisation)
//   loader_state_t    : loader FSM states
//   byte_lane()       : selects byte k of a word, k=0 is the most significant byte
package imem_pkg;

  localparam int IMEM_SIZE_DEFAULT = 500;
  localparam int BYTES_PER_WORD    = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    WRITE_BYTES,
    DONE,
    ERR
  } loader_state_t;

  // Byte k of the word, MSB first, so that {mem[a],mem[a+1],mem[a+2],mem[a+3]}
  // reassembles the original word.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = word << {idx, 3'b000};
    return shifted[31:24];
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// instruction_loader
//   Accepts 32-bit instruction words over a valid/ready handshake and writes each
//   one as four big-endian byte writes (MSB at the lowest address) to a byte-wide
//   instruction memory port.
//
// Parameters
//   MEM_SIZE   memory size in bytes; last legal word start address is MEM_SIZE-4
//   CNT_WIDTH  width of word_count
//
// Ports
//   clk        system clock (rising edge)
//   rst_n      asynchronous active-low reset
//   start      1-cycle pulse, begins a session at base_addr (priority in every state)
//   base_addr  byte address of the first word, sampled on start
//   word_in    instruction word
//   word_valid word_in/last_word valid
//   last_word  marks word_in as the final word of the session
//   word_ready loader can accept a word this cycle
//   mem_wr_en  byte write strobe
//   mem_addr   byte write address (0 when mem_wr_en=0)
//   mem_data   byte write data (0 when mem_wr_en=0)
//   busy       session in progress
//   done       session completed normally, held until next start
//   overflow   word rejected as out of range, held until next start
//   word_count words fully written this session (wraps)
//   checksum   sum of accepted words mod 2^32 (only with LOADER_CHECKSUM_EN)
//
// Build option
//   LOADER_CHECKSUM_EN : adds the checksum output and its accumulator.
module instruction_loader
  import imem_pkg::*;
#(
  parameter int MEM_SIZE  = IMEM_SIZE_DEFAULT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [31:0]          word_in,
  input  logic                 word_valid,
  input  logic                 last_word,
  output logic                 word_ready,
  output logic                 mem_wr_en,
  output logic [31:0]          mem_addr,
  output logic [7:0]           mem_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_SIZE - BYTES_PER_WORD);

  loader_state_t state;
  logic [31:0]   addr;
  logic [31:0]   word_reg;
  logic          last_reg;
  logic [1:0]    byte_idx;   // byte currently presented on the write port
  logic          wr_en_reg;
  logic [31:0]   wr_addr_reg;
  logic [7:0]    wr_data_reg;

  // start wins over a coincident handshake, so ready drops while start is high.
  assign word_ready = (state == WAIT_WORD) && !start;

  // A restart must suppress the byte that is already queued in the output
  // register, otherwise the aborted word would get one extra byte written.
  assign mem_wr_en = wr_en_reg & ~start;
  assign mem_addr  = start ? 32'd0 : wr_addr_reg;
  assign mem_data  = start ? 8'd0  : wr_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      word_reg    <= '0;
      last_reg    <= 1'b0;
      byte_idx    <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      word_count  <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      if (start) begin
        state      <= WAIT_WORD;
        addr       <= base_addr;
        word_count <= '0;
        done       <= 1'b0;
        overflow   <= 1'b0;
        busy       <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
        checksum   <= '0;
`endif
      end else begin
        case (state)
          WAIT_WORD: begin
            if (word_valid) begin
              if (addr > LAST_WORD_ADDR) begin
                state    <= ERR;
                overflow <= 1'b1;
                busy     <= 1'b0;
              end else begin
                // Byte 0 goes out in the cycle right after the handshake.
                word_reg    <= word_in;
                last_reg    <= last_word;
                byte_idx    <= 2'd0;
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= addr;
                wr_data_reg <= byte_lane(word_in, 2'd0);
                state       <= WRITE_BYTES;
`ifdef LOADER_CHECKSUM_EN
                checksum    <= checksum + word_in;
`endif
              end
            end
          end
          WRITE_BYTES: begin
            if (byte_idx == 2'd3) begin
              addr       <= addr + 32'(BYTES_PER_WORD);
              word_count <= word_count + 1'b1;
              if (last_reg) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= WAIT_WORD;
              end
            end else begin
              byte_idx    <= byte_idx + 2'd1;
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= addr + {30'd0, byte_idx} + 32'd1;
              wr_data_reg <= byte_lane(word_reg, byte_idx + 2'd1);
            end
          end
          default: ;  // IDLE, DONE, ERR hold until start
        endcase
      end
    end
  end

endmodule
